mmio_io_bridge: RTL and testbench



---
 rtl/mmio_io_bridge_pkg.sv | 31 +++
 rtl/mmio_io_bridge_sw_debounce.sv | 79 +++++++
 rtl/mmio_io_bridge.sv | 113 +++++++++++
 tb/tb_mmio_io_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_io_bridge_pkg.sv
// Shared definitions for the data-memory-side I/O bridge.
// Holds the I/O window address constants, the bus widths, and the
// register selector used by the bridge's write decode and read mux.
package mmio_io_bridge_pkg;

   localparam int DATA_W = 32;
   localparam int SW_W   = 16;

   // Word addresses of the four I/O registers
   localparam logic [31:0] ADDR_SW    = 32'd4096;
   localparam logic [31:0] ADDR_LED   = 32'd4097;
   localparam logic [31:0] ADDR_FLAGS = 32'd4098;
   localparam logic [31:0] ADDR_CYCLE = 32'd4099;

   // Upper 30 bits shared by every address in the I/O window
   localparam logic [29:0] IO_BASE_WORD = 30'd1024;

   // The low two address bits pick a register inside the window
   typedef enum logic [1:0] {
      REG_SW     = 2'd0,
      REG_LED    = 2'd1,
      REG_FLAGS  = 2'd2,
      REG_CYCLE  = 2'd3
   } io_reg_e;

   // True when a word address falls inside the 4-word I/O window
   function automatic logic isIoAddr(input logic [DATA_W-1:0] addr);
      return (addr[DATA_W-1:2] == IO_BASE_WORD);
   endfunction

endpackage

// File: rtl/mmio_io_bridge_sw_debounce.sv
// Switch synchronizer and debouncer.
// Ports:
//   clock      system clock
//   reset      asynchronous active-low reset
//   sw_i       raw switch vector, asynchronous to clock
//   stable_o   last accepted (debounced) switch vector
//   update_o   high for the one cycle whose posedge loads a new stable value
//   changed_o  bits that change at that posedge (valid while update_o is high)
// A new vector is accepted only after it has been seen unchanged at the
// synchronizer output for DEBOUNCE_CYCLES consecutive comparisons; the
// partial count is thrown away whenever the input moves.
module sw_debounce
   import mmio_io_bridge_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [SW_W-1:0] sw_i,
   output logic [SW_W-1:0] stable_o,
   output logic            update_o,
   output logic [SW_W-1:0] changed_o
);

   logic [SW_W-1:0]  sync1_q;
   logic [SW_W-1:0]  sync2_q;
   logic [SW_W-1:0]  swPrev_q;
   logic [SW_W-1:0]  stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Two-flop synchronizer followed by one more flop, so the debouncer
   // can tell whether the synchronized input moved since last cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         swPrev_q <= '0;
      end else begin
         sync1_q  <= sw_i;
         sync2_q  <= sync1_q;
         swPrev_q <= sync2_q;
      end
   end

   // Debounce counter: counts cycles in which the synchronized input is
   // both unchanged and different from the accepted value.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      update_o = 1'b0;
      if (sync2_q != swPrev_q) begin
         cnt_d = '0;
      end else if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         update_o = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign changed_o = stable_q ^ sync2_q;
   assign stable_o  = stable_q;

   // Accepted vector and counter state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/mmio_io_bridge.sv
// Data-memory-side bridge between the processor dmem port, the data RAM,
// the board switches and the LEDs.
// Ports:
//   clock         system clock
//   reset         asynchronous active-low reset
//   address_dmem  processor word address
//   data          processor store data
//   wren          processor store enable
//   q_ram         read data from the data RAM
//   q_dmem        read data returned to the processor (combinational)
//   ram_wren      store enable forwarded to the RAM (suppressed for I/O)
//   SW            raw switches, asynchronous to clock
//   LED           LED register
// Word addresses 4096..4099 map to SW_STABLE (RO), LED (RW), SW_FLAGS
// (read / write-1-to-clear) and CYCLE (RW free-running counter).
module mmio_io_bridge
   import mmio_io_bridge_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] address_dmem,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   input  logic [DATA_W-1:0] q_ram,
   output logic [DATA_W-1:0] q_dmem,
   output logic              ram_wren,
   input  logic [SW_W-1:0]   SW,
   output logic [SW_W-1:0]   LED
);

   logic            ioSel;
   io_reg_e         regSel;
   logic            ledWrite, flagsWrite, cycWrite;
   logic [SW_W-1:0] swStable;
   logic            swUpdate;
   logic [SW_W-1:0] swChanged;
   logic [SW_W-1:0] setBits;

   logic [SW_W-1:0]   led_q, led_d;
   logic [SW_W-1:0]   flags_q, flags_d;
   logic [DATA_W-1:0] cyc_q, cyc_d;

   sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_sw_debounce (
      .clock     (clock),
      .reset     (reset),
      .sw_i      (SW),
      .stable_o  (swStable),
      .update_o  (swUpdate),
      .changed_o (swChanged)
   );

   // Address decode: I/O stores never reach the RAM
   assign ioSel      = isIoAddr(address_dmem);
   assign regSel     = io_reg_e'(address_dmem[1:0]);
   assign ram_wren   = wren & ~ioSel;
   assign ledWrite   = wren & ioSel & (regSel == REG_LED);
   assign flagsWrite = wren & ioSel & (regSel == REG_FLAGS);
   assign cycWrite   = wren & ioSel & (regSel == REG_CYCLE);

   // Next-state for the register file. New change bits are OR'd in after
   // the clear so a bit set and cleared in the same cycle stays set.
   always_comb begin
      led_d   = led_q;
      setBits = swUpdate ? swChanged : '0;
      flags_d = flags_q | setBits;
      cyc_d   = cyc_q + 32'd1;
      if (ledWrite) begin
         led_d = data[SW_W-1:0];
      end
      if (flagsWrite) begin
         flags_d = (flags_q & ~data[SW_W-1:0]) | setBits;
      end
      if (cycWrite) begin
         cyc_d = data;
      end
   end

   // Register file state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         led_q   <= '0;
         flags_q <= '0;
         cyc_q   <= '0;
      end else begin
         led_q   <= led_d;
         flags_q <= flags_d;
         cyc_q   <= cyc_d;
      end
   end

   // Read mux: purely combinational, reads have no side effects
   always_comb begin
      q_dmem = q_ram;
      if (ioSel) begin
         case (regSel)
            REG_SW:    q_dmem = {16'b0, swStable};
            REG_LED:   q_dmem = {16'b0, led_q};
            REG_FLAGS: q_dmem = {16'b0, flags_q};
            REG_CYCLE: q_dmem = cyc_q;
            default:   q_dmem = q_ram;
         endcase
      end
   end

   assign LED = led_q;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Self-checking bench for mmio_io_bridge with a short debounce window.
module tb_mmio_io_bridge;

   localparam int DB = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address_dmem = '0;
   logic [31:0] data = '0;
   logic        wren = 1'b0;
   logic [31:0] q_ram = '0;
   logic [15:0] SW = '0;
   logic [31:0] q_dmem;
   logic        ram_wren;
   logic [15:0] LED;

   int nCompared = 0;
   int nMismatched = 0;

   // Behavioural model state
   logic [15:0] mLed = '0, mFlags = '0, mStable = '0;
   logic [31:0] mCyc = '0;
   logic [15:0] hist[$];

   mmio_io_bridge #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_ram        (q_ram),
      .q_dmem       (q_dmem),
      .ram_wren     (ram_wren),
      .SW           (SW),
      .LED          (LED)
   );

   always #10 clock = ~clock;

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic modelIsIo(input logic [31:0] addr);
      return (addr >= 32'd4096) && (addr <= 32'd4099);
   endfunction

   function automatic void modelReset();
      mLed = '0; mFlags = '0; mStable = '0; mCyc = '0;
      hist.delete();
      for (int i = 0; i < DB + 2; i++) hist.push_back(16'h0);
   endfunction

   // A switch vector is accepted once the synchronized samples taken
   // 2..DB+2 edges ago all agree and differ from the current accepted value.
   function automatic void modelStep();
      logic        upd;
      logic        wr;
      logic [15:0] setB, clr;
      upd = (hist[1] != mStable);
      for (int i = 1; i <= DB + 1; i++) if (hist[i] != hist[1]) upd = 1'b0;
      setB = upd ? (mStable ^ hist[1]) : 16'h0;
      wr   = wren && modelIsIo(address_dmem);
      clr  = (wr && address_dmem == 32'd4098) ? data[15:0] : 16'h0;
      mFlags = (mFlags & ~clr) | setB;
      if (wr && address_dmem == 32'd4097) mLed = data[15:0];
      mCyc = (wr && address_dmem == 32'd4099) ? data : mCyc + 32'd1;
      if (upd) mStable = hist[1];
      hist.push_front(SW);
      void'(hist.pop_back());
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] addr, input logic [31:0] qr);
      case (addr)
         32'd4096: return {16'h0, mStable};
         32'd4097: return {16'h0, mLed};
         32'd4098: return {16'h0, mFlags};
         32'd4099: return mCyc;
         default:  return qr;
      endcase
   endfunction

   initial modelReset();

   always @(posedge clock or negedge reset) begin
      if (!reset) modelReset();
      else modelStep();
   end

   // Every-cycle comparison against the model, mid-cycle
   always @(negedge clock) begin
      if (reset) begin
         compare("q_dmem", q_dmem, modelRead(address_dmem, q_ram));
         compare("ram_wren", {31'b0, ram_wren}, {31'b0, wren && !modelIsIo(address_dmem)});
         compare("LED", {16'b0, LED}, {16'b0, mLed});
      end
   end

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] dat, input logic we);
      address_dmem = addr;
      data = dat;
      wren = we;
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] addr, input logic [31:0] exp);
      applyStimulus(addr, 32'h0, 1'b0);
      #1;
      compare(name, q_dmem, exp);
   endtask

   initial begin
      #3 reset = 1'b0;
      tick(3);
      reset = 1'b1;

      // LED store and RAM pass-through
      applyStimulus(32'd4097, 32'h1234ABCD, 1'b1);
      #1 compare("led_store_ram_wren", {31'b0, ram_wren}, 32'd0);
      tick();
      checkOutput("led_read", 32'd4097, 32'h0000ABCD);
      compare("led_port", {16'b0, LED}, 32'h0000ABCD);
      applyStimulus(32'd100, 32'h55, 1'b1);
      #1 compare("ram_store_wren", {31'b0, ram_wren}, 32'd1);
      tick();
      q_ram = 32'hDEADBEEF;
      checkOutput("ram_load", 32'd100, 32'hDEADBEEF);

      // Clean switch change reaches stable after exactly 11 posedges
      SW = 16'h00F0;
      applyStimulus(32'd4096, 32'h0, 1'b0);
      tick(10);
      checkOutput("stable_before", 32'd4096, 32'h0);
      tick();
      checkOutput("stable_after", 32'd4096, 32'h00F0);
      checkOutput("flags_after", 32'd4098, 32'h00F0);

      // Short glitch and fast toggling never get through
      SW = 16'h00F1;
      tick(5);
      SW = 16'h00F0;
      tick(20);
      checkOutput("glitch_stable", 32'd4096, 32'h00F0);
      checkOutput("glitch_flags", 32'd4098, 32'h00F0);
      for (int i = 0; i < 10; i++) begin
         SW = SW ^ 16'h0001;
         tick(4);
      end
      SW = 16'h00F0;
      tick(20);
      checkOutput("toggle_stable", 32'd4096, 32'h00F0);

      // Write-1-to-clear, then set colliding with clear on bit 4
      applyStimulus(32'd4098, 32'h0010, 1'b1);
      tick();
      checkOutput("w1c", 32'd4098, 32'h00E0);
      SW = 16'h00E0;
      tick(10);
      applyStimulus(32'd4098, 32'h0010, 1'b1);
      tick();
      checkOutput("set_wins", 32'd4098, 32'h00F0);
      checkOutput("stable_e0", 32'd4096, 32'h00E0);

      // Cycle counter load and wrap
      applyStimulus(32'd4099, 32'hFFFFFFFE, 1'b1);
      tick();
      checkOutput("cyc_load", 32'd4099, 32'hFFFFFFFE);
      tick();
      checkOutput("cyc_inc", 32'd4099, 32'hFFFFFFFF);
      tick();
      checkOutput("cyc_wrap", 32'd4099, 32'h00000000);
      applyStimulus(32'd4099, 32'd5, 1'b1);
      tick();
      checkOutput("cyc_write5", 32'd4099, 32'd5);

      // Asynchronous reset mid-debounce
      applyStimulus(32'd4097, 32'h0000ABCD, 1'b1);
      tick();
      applyStimulus(32'd4096, 32'h0, 1'b0);
      SW = 16'h0F00;
      tick(4);
      #2 reset = 1'b0;
      #1 compare("rst_led_port", {16'b0, LED}, 32'h0);
      checkOutput("rst_led", 32'd4097, 32'h0);
      checkOutput("rst_stable", 32'd4096, 32'h0);
      checkOutput("rst_flags", 32'd4098, 32'h0);
      checkOutput("rst_cyc", 32'd4099, 32'h0);
      tick(2);
      reset = 1'b1;
      applyStimulus(32'd4096, 32'h0, 1'b0);
      tick(10);
      checkOutput("restart_before", 32'd4096, 32'h0);
      tick();
      checkOutput("restart_after", 32'd4096, 32'h0F00);
      checkOutput("restart_flags", 32'd4098, 32'h0F00);

      // Randomized traffic checked by the model every cycle
      for (int i = 0; i < 1500; i++) begin
         int r;
         logic [31:0] a;
         r = $urandom_range(0, 9);
         if (r < 6) a = 32'd4096 + 32'($urandom_range(0, 3));
         else if (r < 8) a = 32'($urandom_range(0, 5000));
         else a = $urandom;
         applyStimulus(a, $urandom, 1'($urandom_range(0, 1)));
         q_ram = $urandom;
         if ($urandom_range(0, 15) == 0) SW = 16'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
